// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with request FSM and instruction buffer
//
// Purpose: fetches instruction words from memory at the current pc and queues
// them for the decoder in a small FIFO. A redirect flushes the queue, and any
// request already in flight has its data discarded.
//
// Ports:
//   clock, reset             single clock, asynchronous active-high reset
//   pc, redirect             program counter value; redirect marks a pc load
//   incr_pc                  pulse: PC register increments at the next edge
//   mem_req, mem_addr        memory read request and its address
//   mem_ack, mem_data        memory completion strobe and the read word
//   instr, instr_pc          head instruction and the address it came from
//   instr_valid, instr_ready head entry present / decoder accepts it

module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  output logic              incr_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic issue;
  logic push;
  logic pop;

  // Next-state and strobes. The FSM only leaves IDLE from IDLE itself, so an
  // ack cycle (incr_pc high) is always followed by one IDLE cycle in which the
  // already-incremented pc is sampled.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    incr_pc    = 1'b0;
    case (state)
      IDLE: begin
        if (count < FULL && !redirect) begin
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next = IDLE;
          if (!redirect) begin
            push    = 1'b1;
            incr_pc = 1'b1;
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign instr_valid = (count != '0);
  // Redirect flushes the queue, so a pop in the same cycle is meaningless.
  assign pop         = instr_valid && instr_ready && !redirect;
  assign mem_req     = (state == REQ) || (state == DROP);
  assign mem_addr    = addr_q;

  // Head outputs read as zero when empty, which also gives zero after reset
  // without resetting the storage array.
  assign instr    = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc = instr_valid ? fifo_addr[rd_ptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Address is latched only on issue, so it holds for the whole request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_addr[wr_ptr] <= addr_q;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the width of the PC and memory address.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the width of the instruction word.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of instruction buffer entries (power of two, at least 2).
REQ-004 Port clock: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-006 Port pc: input, ADDR_W bits, the current program counter value from the PC register.
REQ-007 Port redirect: input, 1 bit, asserted in the same cycle the PC register is loaded (branch or jump); requests a flush.
REQ-008 Port incr_pc: output, 1 bit, one-cycle pulse commanding the PC register to increment at the next edge.
REQ-009 Port mem_req: output, 1 bit, instruction memory read request.
REQ-010 Port mem_addr: output, ADDR_W bits, the read address, valid while mem_req=1.
REQ-011 Port mem_ack: input, 1 bit, memory completion strobe; mem_data is valid in the same cycle.
REQ-012 Port mem_data: input, DATA_W bits, the read instruction word.
REQ-013 Port instr: output, DATA_W bits, the instruction at the buffer head.
REQ-014 Port instr_pc: output, ADDR_W bits, the address the head instruction was fetched from.
REQ-015 Port instr_valid: output, 1 bit, asserted when the buffer is non-empty.
REQ-016 Port instr_ready: input, 1 bit, asserted when the decoder accepts the head entry.

Function
REQ-017 The FSM SHALL have three states: IDLE (no request outstanding), REQ (request outstanding, data kept), and DROP (request outstanding, data discarded).
REQ-018 In IDLE, with count<DEPTH and redirect=0, the block SHALL latch mem_addr<=pc and enter REQ; mem_req SHALL be high from the next cycle.
REQ-019 mem_req SHALL equal (state==REQ or state==DROP); mem_addr SHALL stay constant while mem_req=1, and an issued request SHALL never be withdrawn.
REQ-020 In REQ, on mem_ack=1 with redirect=0, the block SHALL push {mem_addr, mem_data}, pulse incr_pc high for exactly that cycle, and return to IDLE.
REQ-021 The IDLE-to-REQ transition SHALL occur no earlier than the cycle after an incr_pc pulse, so pc is never sampled stale; the ack-to-next-mem_req minimum spacing is 2 cycles.
REQ-022 A pop SHALL occur when instr_valid=1 and instr_ready=1; instr and instr_pc SHALL advance to the next entry at that edge.
REQ-023 A simultaneous push and pop SHALL leave count unchanged, and the buffer SHALL support a push while full-then-popping in the same cycle.
REQ-024 count SHALL never exceed DEPTH; with count==DEPTH no request SHALL issue; read and write pointers SHALL wrap modulo DEPTH.
REQ-025 On redirect=1 the buffer SHALL be emptied at that edge, and redirect SHALL take priority over push and pop in the same cycle.
REQ-026 On redirect=1 in REQ without mem_ack, the FSM SHALL go to DROP; in DROP, mem_ack SHALL discard the data, return to IDLE, and leave incr_pc low.
REQ-027 On redirect=1 coinciding with mem_ack in REQ, the data SHALL be discarded, incr_pc SHALL stay 0, and the FSM SHALL go to IDLE.
REQ-028 No request SHALL be issued in a cycle with redirect=1; the first fetch after a redirect SHALL use the newly loaded pc, sampled the following cycle.
REQ-029 A mem_ack received in IDLE SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, count=0, pointers=0, mem_req=0, mem_addr=0, incr_pc=0, instr_valid=0, instr=0, and instr_pc=0.
REQ-031 A reset mid-request SHALL abandon the request with no push; the fetch SHALL restart from pc in the first cycle after reset deasserts.

Verification
REQ-032 Reset release, pc=0x0000, mem_ack one cycle after each mem_req, instr_ready=1 -> mem_addr sequence 0x0000, 0x0001, 0x0002, an incr_pc pulse per ack, and instr_pc matching each address.
REQ-033 instr_ready=0, DEPTH=2 -> exactly 2 entries fill, then mem_req stays 0; raising instr_ready for 1 cycle -> one pop and exactly one new request.
REQ-034 redirect with pc loaded to 0x0040 while a request to 0x0005 is outstanding -> buffer empty, ack for 0x0005 dropped, no incr_pc, next mem_addr=0x0040.
REQ-035 redirect in the same cycle as mem_ack -> no push, incr_pc=0, instr_valid=0 next cycle.
REQ-036 reset asserted while mem_req=1 -> all outputs 0 asynchronously; after release the first mem_addr equals the current pc.
REQ-037 Full buffer with pop and push in the same cycle -> count stays 2, and entries stay in FIFO order across a pointer wrap.
